// File: rtl/mem_addr_pkg.sv
// Shared types and dual-rail helpers for the memory-address sequencer.
package mem_addr_pkg;

    typedef enum logic [1:0] {
        S_NULL = 2'd0,
        S_DATA = 2'd1,
        S_RTZ  = 2'd2
    } state_t;

    function automatic logic dr_is_null(input logic t, input logic f);
        return !t && !f;
    endfunction

    function automatic logic dr_onehot(input logic t, input logic f);
        return t ^ f;
    endfunction

endpackage

// File: rtl/dr_complete.sv
// Completion detector for W dual-rail pairs: all-valid, all-NULL and any-11 flags.
module dr_complete
    import mem_addr_pkg::*;
#(
    parameter int unsigned W = 5
) (
    input  logic [W-1:0] d_t,
    input  logic [W-1:0] d_f,
    output logic         complete,
    output logic         null_all,
    output logic         illegal_any
);

    always_comb begin
        complete    = 1'b1;
        null_all    = 1'b1;
        illegal_any = 1'b0;
        for (int unsigned i = 0; i < W; i++) begin
            complete    = complete & dr_onehot(d_t[i], d_f[i]);
            null_all    = null_all & dr_is_null(d_t[i], d_f[i]);
            illegal_any = illegal_any | (d_t[i] & d_f[i]);
        end
    end

endmodule

// File: rtl/mem_addr_dr_seq.sv
// Dual-rail address generator: picks PC or operand on ph0, latches a complete code
// and offers it to memory with a 4-phase req/ack handshake plus sticky error flags.
module mem_addr_dr_seq
    import mem_addr_pkg::*;
#(
    parameter int unsigned ADDR_W  = 4,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ph0_t,
    input  logic              ph0_f,
    input  logic [ADDR_W-1:0] pc_t,
    input  logic [ADDR_W-1:0] pc_f,
    input  logic [ADDR_W-1:0] imm_t,
    input  logic [ADDR_W-1:0] imm_f,
    input  logic              mem_ack,
    output logic [ADDR_W-1:0] a_t,
    output logic [ADDR_W-1:0] a_f,
    output logic              addr_req,
    output logic              err_illegal,
    output logic              err_timeout
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    // Reset asserts asynchronously, releases after two clean edges.
    logic [1:0] rst_sync_q, rst_sync_d;
    logic       rst_int_n;

    always_comb rst_sync_d = {rst_sync_q[0], 1'b1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync_q <= 2'b00;
        else        rst_sync_q <= rst_sync_d;
    end

    assign rst_int_n = rst_sync_q[1];

    logic [ADDR_W-1:0] sel_t_c, sel_f_c;
    logic              complete_c, null_sel_c, illegal_sel_c;
    logic              illegal_in_c, null_in_c;

    assign sel_t_c = ph0_t ? pc_t : imm_t;
    assign sel_f_c = ph0_t ? pc_f : imm_f;

    dr_complete #(.W(ADDR_W + 1)) u_complete (
        .d_t         ({ph0_t, sel_t_c}),
        .d_f         ({ph0_f, sel_f_c}),
        .complete    (complete_c),
        .null_all    (null_sel_c),
        .illegal_any (illegal_sel_c)
    );

    // The unselected source still counts for illegal codes and return-to-NULL.
    assign illegal_in_c = illegal_sel_c | (|(pc_t & pc_f)) | (|(imm_t & imm_f));
    assign null_in_c    = null_sel_c & ~(|{pc_t, pc_f, imm_t, imm_f});

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] a_t_q, a_t_d, a_f_q, a_f_d;
    logic              addr_req_q, addr_req_d;
    logic              err_illegal_q, err_illegal_d;
    logic              err_timeout_q, err_timeout_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc_c;

    assign cnt_inc_c = cnt_q + CNT_W'(1);

    always_comb begin
        state_d       = state_q;
        a_t_d         = a_t_q;
        a_f_d         = a_f_q;
        addr_req_d    = addr_req_q;
        cnt_d         = cnt_q;
        err_illegal_d = err_illegal_q | illegal_in_c;
        err_timeout_d = err_timeout_q;

        case (state_q)
            S_NULL: begin
                a_t_d      = '0;
                a_f_d      = '0;
                addr_req_d = 1'b0;
                cnt_d      = '0;
                if (complete_c && !mem_ack) begin
                    a_t_d      = sel_t_c;
                    a_f_d      = sel_f_c;
                    addr_req_d = 1'b1;
                    state_d    = S_DATA;
                end
            end
            S_DATA: begin
                // Ack on the timeout edge takes priority over the error.
                if (mem_ack || cnt_inc_c == CNT_W'(TIMEOUT)) begin
                    err_timeout_d = err_timeout_q | !mem_ack;
                    a_t_d         = '0;
                    a_f_d         = '0;
                    addr_req_d    = 1'b0;
                    cnt_d         = '0;
                    state_d       = S_RTZ;
                end else begin
                    cnt_d = cnt_inc_c;
                end
            end
            S_RTZ: begin
                a_t_d      = '0;
                a_f_d      = '0;
                addr_req_d = 1'b0;
                cnt_d      = '0;
                if (null_in_c && !mem_ack) state_d = S_NULL;
            end
            default: begin
                a_t_d      = '0;
                a_f_d      = '0;
                addr_req_d = 1'b0;
                cnt_d      = '0;
                state_d    = S_NULL;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q       <= S_NULL;
            a_t_q         <= '0;
            a_f_q         <= '0;
            addr_req_q    <= 1'b0;
            cnt_q         <= '0;
            err_illegal_q <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            a_t_q         <= a_t_d;
            a_f_q         <= a_f_d;
            addr_req_q    <= addr_req_d;
            cnt_q         <= cnt_d;
            err_illegal_q <= err_illegal_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign a_t         = a_t_q;
    assign a_f         = a_f_q;
    assign addr_req    = addr_req_q;
    assign err_illegal = err_illegal_q;
    assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_mem_addr_dr_seq.sv
// Directed scenarios plus randomized traffic, checked against a transaction-level model.
module tb_mem_addr_dr_seq;

    localparam int unsigned AW = 4;
    localparam int unsigned TO = 15;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ph0_t, ph0_f, mem_ack;
    logic [AW-1:0] pc_t, pc_f, imm_t, imm_f;
    logic [AW-1:0] a_t, a_f;
    logic          addr_req, err_illegal, err_timeout;

    int n_cmp = 0;
    int n_mis = 0;

    // Reference: an address is either being offered, draining to NULL, or idle.
    bit            m_busy, m_drain, m_ill, m_to;
    int            m_age;
    logic [AW-1:0] m_at, m_af;

    mem_addr_dr_seq #(.ADDR_W(AW), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ph0_t       (ph0_t),
        .ph0_f       (ph0_f),
        .pc_t        (pc_t),
        .pc_f        (pc_f),
        .imm_t       (imm_t),
        .imm_f       (imm_f),
        .mem_ack     (mem_ack),
        .a_t         (a_t),
        .a_f         (a_f),
        .addr_req    (addr_req),
        .err_illegal (err_illegal),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_busy = 0; m_drain = 0; m_ill = 0; m_to = 0; m_age = 0;
        m_at = '0; m_af = '0;
    endtask

    task automatic model_edge();
        logic [AW-1:0] st, sf;
        if ((ph0_t & ph0_f) || (pc_t & pc_f) != 0 || (imm_t & imm_f) != 0) m_ill = 1;
        if (m_busy) begin
            if (mem_ack) begin
                m_busy = 0; m_drain = 1;
            end else begin
                m_age++;
                if (m_age >= int'(TO)) begin
                    m_to = 1; m_busy = 0; m_drain = 1;
                end
            end
        end else if (m_drain) begin
            if (!ph0_t && !ph0_f && pc_t == 0 && pc_f == 0 && imm_t == 0 && imm_f == 0 && !mem_ack)
                m_drain = 0;
        end else begin
            st = ph0_t ? pc_t : imm_t;
            sf = ph0_t ? pc_f : imm_f;
            if ((ph0_t != ph0_f) && ((st ^ sf) == {AW{1'b1}}) && !mem_ack) begin
                m_busy = 1; m_at = st; m_af = sf; m_age = 0;
            end
        end
    endtask

    task automatic compare_model();
        check_eq("req", 32'(addr_req), 32'(m_busy));
        check_eq("a_t", 32'(a_t), m_busy ? 32'(m_at) : 32'd0);
        check_eq("a_f", 32'(a_f), m_busy ? 32'(m_af) : 32'd0);
        check_eq("err_illegal", 32'(err_illegal), 32'(m_ill));
        check_eq("err_timeout", 32'(err_timeout), 32'(m_to));
    endtask

    // Apply inputs, clock once, then sample 1 time unit after the edge.
    task automatic step(input logic p_t, input logic p_f, input logic [AW-1:0] pct,
                        input logic [AW-1:0] pcf, input logic [AW-1:0] imt,
                        input logic [AW-1:0] imf, input logic ack);
        ph0_t = p_t; ph0_f = p_f; pc_t = pct; pc_f = pcf;
        imm_t = imt; imm_f = imf; mem_ack = ack;
        @(posedge clk);
        model_edge();
        #1;
        compare_model();
    endtask

    task automatic step_null(input logic ack);
        step(1'b0, 1'b0, '0, '0, '0, '0, ack);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ph0_t = 0; ph0_f = 0; pc_t = '0; pc_f = '0; imm_t = '0; imm_f = '0; mem_ack = 0;
        model_clear();
        #1;
        check_eq("rst_a_t", 32'(a_t), 32'd0);
        check_eq("rst_req", 32'(addr_req), 32'd0);
        check_eq("rst_errs", 32'({err_illegal, err_timeout}), 32'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (3) step_null(1'b0);
    endtask

    initial begin
        logic [AW-1:0] v, w, cpt, cpf, cit, cif;
        logic          cp0t, cp0f, cack;
        int            ack_p, r, k;

        do_reset();

        // PC fetch
        v = 4'b1010;
        step(1'b1, 1'b0, v, ~v, '0, '0, 1'b0);
        check_eq("pc_at", 32'(a_t), 32'hA);
        check_eq("pc_af", 32'(a_f), 32'h5);
        check_eq("pc_req", 32'(addr_req), 32'd1);
        step(1'b1, 1'b0, v, ~v, '0, '0, 1'b1);
        check_eq("pc_ack_req", 32'(addr_req), 32'd0);
        check_eq("pc_ack_at", 32'(a_t), 32'd0);
        step_null(1'b0);

        // Operand path, PC changing while DATA is held
        v = 4'b0011;
        step(1'b0, 1'b1, '0, '0, v, ~v, 1'b0);
        check_eq("imm_at", 32'(a_t), 32'h3);
        check_eq("imm_af", 32'(a_f), 32'hC);
        w = 4'b0110;
        step(1'b1, 1'b0, w, ~w, v, ~v, 1'b0);
        check_eq("imm_hold_at", 32'(a_t), 32'h3);
        check_eq("imm_hold_af", 32'(a_f), 32'hC);
        step(1'b0, 1'b1, '0, '0, v, ~v, 1'b1);
        step_null(1'b0);

        // Partial operand: bit2 rails both low
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, '0, '0, 4'b0001, 4'b1010, 1'b0);
            check_eq("partial_req", 32'(addr_req), 32'd0);
            check_eq("partial_at", 32'(a_t), 32'd0);
        end
        step(1'b0, 1'b1, '0, '0, 4'b0101, 4'b1010, 1'b0);
        check_eq("partial_done_at", 32'(a_t), 32'h5);
        step(1'b0, 1'b1, '0, '0, 4'b0101, 4'b1010, 1'b1);
        step_null(1'b0);

        // Ack arriving exactly on the timeout edge
        v = 4'b1100;
        step(1'b1, 1'b0, v, ~v, '0, '0, 1'b0);
        for (int i = 0; i < int'(TO) - 1; i++) step(1'b1, 1'b0, v, ~v, '0, '0, 1'b0);
        check_eq("edge_req_still", 32'(addr_req), 32'd1);
        step(1'b1, 1'b0, v, ~v, '0, '0, 1'b1);
        check_eq("edge_no_timeout", 32'(err_timeout), 32'd0);
        check_eq("edge_req_drop", 32'(addr_req), 32'd0);
        step_null(1'b0);

        // Genuine timeout
        step(1'b1, 1'b0, v, ~v, '0, '0, 1'b0);
        for (int i = 0; i < int'(TO) - 1; i++) step(1'b1, 1'b0, v, ~v, '0, '0, 1'b0);
        check_eq("to_before", 32'(err_timeout), 32'd0);
        step(1'b1, 1'b0, v, ~v, '0, '0, 1'b0);
        check_eq("to_flag", 32'(err_timeout), 32'd1);
        check_eq("to_req", 32'(addr_req), 32'd0);
        step_null(1'b0);

        // Illegal pc bit0 blocks the transfer until fixed
        step(1'b1, 1'b0, 4'b0101, 4'b1011, '0, '0, 1'b0);
        check_eq("ill_flag", 32'(err_illegal), 32'd1);
        check_eq("ill_req", 32'(addr_req), 32'd0);
        step(1'b1, 1'b0, 4'b0101, 4'b1010, '0, '0, 1'b0);
        check_eq("ill_fixed_at", 32'(a_t), 32'h5);
        check_eq("ill_sticky", 32'(err_illegal), 32'd1);
        step(1'b1, 1'b0, 4'b0101, 4'b1010, '0, '0, 1'b1);
        step_null(1'b0);

        // Asynchronous reset while DATA is on the outputs
        v = 4'b1001;
        step(1'b1, 1'b0, v, ~v, '0, '0, 1'b0);
        check_eq("arst_pre_req", 32'(addr_req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_req", 32'(addr_req), 32'd0);
        check_eq("arst_at", 32'(a_t), 32'd0);
        check_eq("arst_af", 32'(a_f), 32'd0);
        check_eq("arst_errs", 32'({err_illegal, err_timeout}), 32'd0);
        do_reset();

        // Randomized traffic
        cp0t = 0; cp0f = 0; cpt = '0; cpf = '0; cit = '0; cif = '0;
        ack_p = 30;
        for (int n = 0; n < 4000; n++) begin
            if (n % 200 == 0) begin
                k = int'($urandom_range(0, 2));
                ack_p = (k == 0) ? 2 : (k == 1) ? 25 : 60;
            end
            r = int'($urandom_range(0, 99));
            if (r < 45) begin
                // hold previous inputs
            end else if (r < 62) begin
                cp0t = 0; cp0f = 0; cpt = '0; cpf = '0; cit = '0; cif = '0;
            end else if (r < 84) begin
                cp0t = 1'($urandom_range(0, 1)); cp0f = ~cp0t;
                v = 4'($urandom); w = 4'($urandom);
                cpt = v; cpf = ~v; cit = w; cif = ~w;
            end else if (r < 97) begin
                w = 4'(1 << $urandom_range(0, 3));
                if (cp0t) begin cpt = cpt & ~w; cpf = cpf & ~w; end
                else      begin cit = cit & ~w; cif = cif & ~w; end
            end else begin
                w = 4'(1 << $urandom_range(0, 3));
                if ($urandom_range(0, 1) == 1) begin cpt = cpt | w; cpf = cpf | w; end
                else                           begin cit = cit | w; cif = cif | w; end
            end
            cack = (int'($urandom_range(0, 99)) < ack_p);
            step(cp0t, cp0f, cpt, cpf, cit, cif, cack);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
